shared_reg_ctrl: RTL and testbench

- Round-robin controller that shares one WIDTH-bit register (a bank of D flip-flops with load/set/clear) between NREQ requesters.
- Each requester issues a request carrying an opcode and write data.
- The controller grants one requester at a time, executes its operation on the register and returns a one-cycle ack.
- Sits between bus-side requesters and the flip-flop storage; it is the only writer of q.

---
 rtl/shared_reg_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/shared_reg_ctrl.sv | 153 +++++++++++++++
 tb/tb_shared_reg_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register controller: opcodes, FSM states
// and the lock burst cap used when SHARED_REG_LOCK_EN is defined.
package shared_reg_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Longest run of back-to-back grants a locking requester may hold.
    localparam int LOCK_MAX   = 4;
    localparam int LOCK_CNT_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: the first asserted request at or
// above ptr, wrapping modulo NREQ. Returns a one-hot vector and the index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [NREQ-1:0]  onehot,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W:0] sum;

    // Scan offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        sum    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(NREQ)) begin
                sum = sum - (PTR_W + 1)'(NREQ);
            end
            if (req[sum[PTR_W-1:0]]) begin
                valid = 1'b1;
                idx   = sum[PTR_W-1:0];
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_reg_ctrl.sv
// Round-robin controller sharing one WIDTH-bit register among NREQ requesters.
// Each operation takes IDLE (arbitrate) -> EXEC (apply op) -> DONE (ack).
// Optional macro SHARED_REG_LOCK_EN adds a lock input that lets the current
// owner keep the register for up to LOCK_MAX consecutive grants.
module shared_reg_ctrl
    import shared_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      q
);

    localparam int PTR_W = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
`ifdef SHARED_REG_LOCK_EN
    logic                  relock_q, relock_d;
    logic [LOCK_CNT_W-1:0] burst_q, burst_d;
`endif

    logic [1:0]       op_arr    [NREQ];
    logic [WIDTH-1:0] wdata_arr [NREQ];

    logic             arb_valid;
    logic [NREQ-1:0]  arb_onehot;
    logic [PTR_W-1:0] arb_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]    = op[2*gi +: 2];
        assign wdata_arr[gi] = wdata[WIDTH*gi +: WIDTH];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    // Next-state, grant/ack and register datapath for the three-phase cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        data_d  = data_q;
`ifdef SHARED_REG_LOCK_EN
        relock_d = relock_q;
        burst_d  = burst_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef SHARED_REG_LOCK_EN
                if (relock_q) begin
                    // Locked owner is re-granted without consulting the arbiter.
                    relock_d     = 1'b0;
                    burst_d      = burst_q + 1'b1;
                    gnt_d        = '0;
                    gnt_d[win_q] = 1'b1;
                    state_d      = EXEC;
                end else
`endif
                if (arb_valid) begin
                    win_d   = arb_idx;
                    gnt_d   = arb_onehot;
                    state_d = EXEC;
`ifdef SHARED_REG_LOCK_EN
                    burst_d = LOCK_CNT_W'(1);
`endif
                end
            end
            EXEC: begin
                case (op_arr[win_q])
                    OP_LOAD: data_d = wdata_arr[win_q];
                    OP_SET:  data_d = '1;
                    OP_CLR:  data_d = '0;
                    default: data_d = data_q;
                endcase
                // A locked re-grant has the same winner, so ptr stays put.
                ptr_d        = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                gnt_d        = '0;
                ack_d[win_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
`ifdef SHARED_REG_LOCK_EN
                relock_d = lock[win_q] && req[win_q]
                           && (burst_q < LOCK_CNT_W'(LOCK_MAX));
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight and clears q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
`ifdef SHARED_REG_LOCK_EN
            relock_q <= 1'b0;
            burst_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
`ifdef SHARED_REG_LOCK_EN
            relock_q <= relock_d;
            burst_q  <= burst_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign busy = (state_q != IDLE);
    assign q    = data_q;

endmodule

// File: tb/tb_shared_reg_ctrl.sv
// Self-checking bench for shared_reg_ctrl (WIDTH=8, NREQ=4): a transaction
// schedule model checked every cycle, plus directed literal expectations.
module tb_shared_reg_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [2*NREQ-1:0] op;
    logic [NREQ*WIDTH-1:0] wdata;
`ifdef SHARED_REG_LOCK_EN
    logic [NREQ-1:0]  lock;
`endif
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             busy;
    logic [WIDTH-1:0] q;

    shared_reg_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .wdata (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts cycles since a grant was issued (0 = no operation open).
    bit         m_on = 0;
    int         m_age, m_w, m_ptr, m_burst;
    bit         m_relock;
    logic [7:0] m_q;
    logic [3:0] m_gnt, m_ack;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (p + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on = 1; m_q = 0; m_ptr = 0; m_age = 0; m_w = 0;
                m_gnt = 0; m_ack = 0; m_relock = 0; m_burst = 0;
            end else if (m_on) begin
                if (m_age == 0) begin
                    if (m_relock) begin
                        m_relock = 0; m_burst++;
                        m_gnt = 4'(1 << m_w); m_age = 1;
                    end else if (req != 0) begin
                        m_w = pick(req, m_ptr); m_burst = 1;
                        m_gnt = 4'(1 << m_w); m_age = 1;
                    end
                end else if (m_age == 1) begin
                    case (op[2*m_w +: 2])
                        2'b00:   m_q = wdata[8*m_w +: 8];
                        2'b01:   m_q = 8'hFF;
                        2'b10:   m_q = 8'h00;
                        default: ;
                    endcase
                    m_ptr = (m_w + 1) % NREQ;
                    m_gnt = 0; m_ack = 4'(1 << m_w); m_age = 2;
                    $display("txn: requester=%0d op=%0d q=%h", m_w, op[2*m_w +: 2], m_q);
                end else begin
                    m_ack = 0; m_age = 0;
`ifdef SHARED_REG_LOCK_EN
                    if (lock[m_w] && req[m_w] && m_burst < 4) m_relock = 1;
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("gnt",  gnt,  m_gnt);
                chk("ack",  ack,  m_ack);
                chk("busy", busy, m_age != 0);
                chk("q",    q,    m_q);
                chk("gnt_onehot", $countones(gnt) <= 1, 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int order[$];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // One request from an idle controller; checks grant, latency and final q.
    task automatic txn(input int i, input logic [1:0] o, input logic [7:0] d,
                       input logic [3:0] exp_gnt, input logic [7:0] exp_q, input string nm);
        int k;
        bit got;
        step();
        op[2*i +: 2] = o; wdata[8*i +: 8] = d; req[i] = 1'b1;
        k = 0; got = 0;
        while (!got && k < 20) begin
            step(); k++;
            if (k == 1) chk({nm, "_gnt"}, gnt, exp_gnt);
            if (ack[i]) got = 1;
        end
        chk({nm, "_ack_lat"}, k, 2);
        chk({nm, "_q"}, q, exp_q);
        req[i] = 1'b0;
    endtask

    // Holds a request mask and records grant order; acked requesters drop
    // (except those in hold) and optionally re-request one cycle later.
    task automatic collect(input int n, input logic [3:0] start, input bit re_en,
                           input logic [3:0] hold);
        logic [3:0] reassert;
        int c;
        order.delete();
        step();
        req = start; reassert = 0; c = 0;
        while (order.size() < n && c < 80) begin
            step(); c++;
            req = req | reassert; reassert = 0;
            if (gnt != 0) order.push_back(idx_of(gnt));
            if (ack != 0) begin
                req = req & ~(ack & ~hold);
                if (re_en) reassert = ack & ~hold;
            end
        end
        chk("collect_count", order.size(), n);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int exp_rr[5];
        int exp_wr[2];
        rst = 1'b1; req = 4'b1111; op = 8'hFF; wdata = '0;
`ifdef SHARED_REG_LOCK_EN
        lock = '0;
`endif
        // Reset held two cycles with all requests asserted.
        step(); step();
        chk("rst_q", q, 8'h00); chk("rst_gnt", gnt, 4'b0000);
        chk("rst_ack", ack, 4'b0000); chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        chk("first_gnt", gnt, 4'b0001);
        req = 4'b0000;                       // dropped while granted: still acked
        step();
        chk("first_ack", ack, 4'b0001);

        txn(2, 2'b00, 8'hA5, 4'b0100, 8'hA5, "load2");
        txn(1, 2'b01, 8'h00, 4'b0010, 8'hFF, "set1");
        txn(1, 2'b10, 8'h00, 4'b0010, 8'h00, "clr1");
        txn(1, 2'b11, 8'h00, 4'b0010, 8'h00, "nop1");
        txn(3, 2'b00, 8'h5A, 4'b1000, 8'h5A, "load3");   // ptr -> 0

        // Round-robin fairness with everyone requesting NOP.
        op = 8'hFF;
        collect(5, 4'b1111, 1'b1, 4'b0000);
        exp_rr = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5 && j < order.size(); j++)
            chk($sformatf("rr_order%0d", j), order[j], exp_rr[j]);
        req = 4'b0000;
        step(); step();

        // Wrap and skip from ptr=3.
        txn(2, 2'b00, 8'h77, 4'b0100, 8'h77, "load2b");  // ptr -> 3
        op[1:0] = 2'b00; wdata[7:0] = 8'h11;
        op[5:4] = 2'b00; wdata[23:16] = 8'h22;
        collect(2, 4'b0101, 1'b0, 4'b0000);
        exp_wr = '{0, 2};
        for (int j = 0; j < 2 && j < order.size(); j++)
            chk($sformatf("wrap_order%0d", j), order[j], exp_wr[j]);
        step();
        chk("wrap_ack", ack, 4'b0100); chk("wrap_q", q, 8'h22);
        req = 4'b0000;

        // Reset during EXEC aborts the operation.
        step();
        op[3:2] = 2'b00; wdata[15:8] = 8'h3C; req[1] = 1'b1;
        step();
        chk("abort_gnt", gnt, 4'b0010);
        rst = 1'b1;
        step();
        chk("abort_q", q, 8'h00); chk("abort_ack", ack, 4'b0000);
        chk("abort_busy", busy, 1'b0); chk("abort_gnt0", gnt, 4'b0000);
        rst = 1'b0; req = 4'b0000;
        step(); step();
        chk("abort_noack", ack, 4'b0000);

`ifdef SHARED_REG_LOCK_EN
        txn(0, 2'b11, 8'h00, 4'b0001, 8'h00, "nop0");   // ptr -> 1
        op[1:0] = 2'b11; op[3:2] = 2'b00; wdata[15:8] = 8'h42;
        lock = 4'b0010;
        collect(5, 4'b0011, 1'b0, 4'b0010);
        begin
            int exp_lk[5];
            exp_lk = '{1, 1, 1, 1, 0};
            for (int j = 0; j < 5 && j < order.size(); j++)
                chk($sformatf("lock_order%0d", j), order[j], exp_lk[j]);
        end
        req = 4'b0000; lock = 4'b0000;
        step(); step(); step();
`endif

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
